// File: rtl/seg_scan_pkg.sv
// Shared types, constants and helpers for the 7-segment digit scanner.
package seg_scan_pkg;

    // Per-slot phase: anodes dark while the decoder settles, then lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Segment and anode lines are active-low, so "off" is a 1.
    localparam logic SEG_OFF = 1'b1;

    // Counter/index width that stays at least one bit for tiny ranges.
    function automatic int unsigned clog2(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Digit data in, multiplexed display drive out.
// master = the clock logic that owns the digit values; slave = the scanner.
interface seg_scan_if
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8
);
    localparam int IDX_W = clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   en_i;
    logic [3:0]              bcd_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    dp_o;
    logic [IDX_W-1:0]        digit_idx_o;
    logic                    frame_o;

    modport master (
        output digits_i, dp_i, en_i,
        input  bcd_o, an_o, dp_o, digit_idx_o, frame_o
    );

    modport slave (
        input  digits_i, dp_i, en_i,
        output bcd_o, an_o, dp_o, digit_idx_o, frame_o
    );

endinterface

// File: rtl/seg_scan_tick.sv
// Slot timer: counts 0..SCAN_DIV-1 and flags the end of the blanking
// window and the last cycle of each digit slot.
module seg_scan_tick
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             end_of_slot,
    output logic             blank_done
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    assign end_of_slot = (cnt == CNT_LAST);
    assign blank_done  = (BLANK_CYCLES != 0) && (cnt == BLANK_LAST);

    // Free-running slot counter, restarted by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt <= '0;
        end else if (end_of_slot) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Drives one BCD nibble and one active-low anode per slot, with a dark gap at
// the start of every slot; digit data is frozen once per frame.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic     clk,
    input  logic     rst,
    seg_scan_if.slave bus
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int CNT_W = clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam scan_state_t      ST_FIRST = (BLANK_CYCLES != 0) ? ST_BLANK : ST_SHOW;

    localparam bit CFG_OK = (NUM_DIGITS >= 2) && (SCAN_DIV >= 1) &&
                            (BLANK_CYCLES >= 0) && (BLANK_CYCLES < SCAN_DIV);

    generate
        if (!CFG_OK) begin : g_cfg_check
            $error("seg_scan: need NUM_DIGITS >= 2 and 0 <= BLANK_CYCLES < SCAN_DIV");
        end
    endgenerate

    // Slot position of the upcoming edge: cnt within the slot, idx_q the digit.
    logic [CNT_W-1:0] cnt;
    logic             end_of_slot;
    logic             blank_done;
    logic [IDX_W-1:0] idx_q;

    scan_state_t state_q, state_d;

    // Frozen copy of the digit data for the frame in progress.
    logic [NUM_DIGITS-1:0][3:0] snap_digits;
    logic [NUM_DIGITS-1:0]      snap_dp;
    logic [NUM_DIGITS-1:0]      snap_en;

    // Data visible to the current edge: the live inputs on the snapshot edge,
    // the frozen copy everywhere else, so slot 0 uses the fresh snapshot.
    logic [NUM_DIGITS-1:0][3:0] cur_digits;
    logic [NUM_DIGITS-1:0]      cur_dp;
    logic [NUM_DIGITS-1:0]      cur_en;
    logic                       frame_edge;

    logic [NUM_DIGITS-1:0] an_d;
    logic                  dp_d;

    seg_scan_tick #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .cnt         (cnt),
        .end_of_slot (end_of_slot),
        .blank_done  (blank_done)
    );

    assign frame_edge = (cnt == '0) && (idx_q == '0);

    // Select live or frozen digit data for this edge.
    always_comb begin
        cur_digits = snap_digits;
        cur_dp     = snap_dp;
        cur_en     = snap_en;
        if (frame_edge) begin
            cur_digits = bus.digits_i;
            cur_dp     = bus.dp_i;
            cur_en     = bus.en_i;
        end
    end

    // Phase FSM next state and the anode/dp drive for this edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        an_d    = '1;
        dp_d    = SEG_OFF;
        case (state_q)
            ST_BLANK: begin
                if (blank_done) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                an_d[idx_q] = ~cur_en[idx_q];
                dp_d        = ~(cur_dp[idx_q] & cur_en[idx_q]);
                if (end_of_slot && (BLANK_CYCLES != 0)) begin
                    state_d = ST_BLANK;
                end
            end
            default: state_d = ST_FIRST;
        endcase
    end

    // Phase register and digit index, advanced at each slot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FIRST;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (end_of_slot) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Capture digit data once per frame, on the first edge of slot 0.
    always_ff @(posedge clk) begin
        // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset to give a dark, known first frame.
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
        end else if (frame_edge) begin
            snap_digits <= bus.digits_i;
            snap_dp     <= bus.dp_i;
            snap_en     <= bus.en_i;
        end
    end

    // Registered display drive; no input reaches an output without a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bcd_o       <= '0;
            bus.an_o        <= '1;
            bus.dp_o        <= SEG_OFF;
            bus.digit_idx_o <= '0;
            bus.frame_o     <= 1'b0;
        end else begin
            bus.bcd_o       <= cur_digits[idx_q];
            bus.an_o        <= an_d;
            bus.dp_o        <= dp_d;
            bus.digit_idx_o <= idx_q;
            bus.frame_o     <= frame_edge;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: NUM_DIGITS=4, SCAN_DIV=8, one instance with
// BLANK_CYCLES=2 and one with no blanking, sharing clock and reset.
module tb_seg_scan;

    localparam int ND  = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(ND)) bus_b ();
    seg_scan_if #(.NUM_DIGITS(ND)) bus_n ();

    seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(0)) u_dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic [3:0][3:0] exp_an;   // [slot] anode pattern while lit
        logic [3:0]      exp_dp;   // bit k = dp_o during SHOW of digit k
        logic [3:0][3:0] exp_bcd;  // [slot] nibble for the whole slot
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        bus_b.digits_i = d;  bus_b.dp_i = dp;  bus_b.en_i = en;
        bus_n.digits_i = d;  bus_n.dp_i = dp;  bus_n.en_i = en;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rst an_b"},  32'(bus_b.an_o), 32'hF);
        check({tag, " rst dp_b"},  32'(bus_b.dp_o), 32'h1);
        check({tag, " rst bcd_b"}, 32'(bus_b.bcd_o), 32'h0);
        check({tag, " rst idx_b"}, 32'(bus_b.digit_idx_o), 32'h0);
        check({tag, " rst frm_b"}, 32'(bus_b.frame_o), 32'h0);
        check({tag, " rst an_n"},  32'(bus_n.an_o), 32'hF);
    endtask

    // Invariants on every cycle once the bench is under way.
    logic [1:0] prev_idx;
    logic [3:0] prev_bcd;
    bit         prev_rst = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            check("inv onehot_b", 32'($countones(~bus_b.an_o) <= 1), 32'h1);
            check("inv onehot_n", 32'($countones(~bus_n.an_o) <= 1), 32'h1);
            if (!prev_rst && !bus_b.frame_o && bus_b.digit_idx_o == prev_idx) begin
                check("inv bcd_stable", 32'(bus_b.bcd_o), 32'(prev_bcd));
            end
        end
        prev_idx = bus_b.digit_idx_o;
        prev_bcd = bus_b.bcd_o;
        prev_rst = rst;
    end

    initial begin
        int         prev_frame;
        logic [15:0] old_d;
        logic [15:0] new_d;
        int         slot;

        vecs[0] = '{16'h4321, 4'b0000, 4'b1111,
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111,
                    {4'h4, 4'h3, 4'h2, 4'h1}};
        vecs[1] = '{16'h9876, 4'b0011, 4'b0101,
                    {4'b1111, 4'b1011, 4'b1111, 4'b1110}, 4'b1110,
                    {4'h9, 4'h8, 4'h7, 4'h6}};
        vecs[2] = '{16'hFA0C, 4'b1100, 4'b1010,
                    {4'b0111, 4'b1111, 4'b1101, 4'b1111}, 4'b0111,
                    {4'hF, 4'hA, 4'h0, 4'hC}};
        vecs[3] = '{16'h5555, 4'b1111, 4'b0000,
                    {4'b1111, 4'b1111, 4'b1111, 4'b1111}, 4'b1111,
                    {4'h5, 4'h5, 4'h5, 4'h5}};

        drive(16'h0, 4'h0, 4'h0);
        rst = 1'b1;
        repeat (2) step();
        mon_en = 1'b1;

        // Table: one full frame per vector, starting from a reset.
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i].digits, vecs[i].dp, vecs[i].en);
            rst = 1'b1;
            step();
            check_reset($sformatf("v%0d", i));
            rst = 1'b0;
            for (int c = 0; c < ND * DIV; c++) begin
                int  s;
                bit  blank;
                step();
                s     = c / DIV;
                blank = (c % DIV) < BLK;
                check($sformatf("v%0d c%0d an_b", i, c), 32'(bus_b.an_o),
                      blank ? 32'hF : 32'(vecs[i].exp_an[s]));
                check($sformatf("v%0d c%0d dp_b", i, c), 32'(bus_b.dp_o),
                      blank ? 32'h1 : 32'(vecs[i].exp_dp[s]));
                check($sformatf("v%0d c%0d bcd_b", i, c), 32'(bus_b.bcd_o), 32'(vecs[i].exp_bcd[s]));
                check($sformatf("v%0d c%0d idx_b", i, c), 32'(bus_b.digit_idx_o), 32'(s));
                check($sformatf("v%0d c%0d frm_b", i, c), 32'(bus_b.frame_o), 32'(c == 0));
                check($sformatf("v%0d c%0d an_n", i, c), 32'(bus_n.an_o), 32'(vecs[i].exp_an[s]));
                check($sformatf("v%0d c%0d dp_n", i, c), 32'(bus_n.dp_o), 32'(vecs[i].exp_dp[s]));
                check($sformatf("v%0d c%0d bcd_n", i, c), 32'(bus_n.bcd_o), 32'(vecs[i].exp_bcd[s]));
            end
        end

        // Mid-frame input change stays invisible until the next snapshot;
        // frame_o recurs every 32 cycles.
        old_d = 16'h4321;
        new_d = 16'h9876;
        drive(old_d, 4'h0, 4'hF);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        prev_frame = -1;
        for (int c = 0; c <= 2 * ND * DIV; c++) begin
            step();
            slot = (c / DIV) % ND;
            if (c == 10) begin
                drive(new_d, 4'h0, 4'hF);
            end
            if (c < ND * DIV) begin
                check($sformatf("snap c%0d bcd_old", c), 32'(bus_b.bcd_o), 32'(old_d[4*slot +: 4]));
            end else begin
                check($sformatf("snap c%0d bcd_new", c), 32'(bus_b.bcd_o), 32'(new_d[4*slot +: 4]));
            end
            if (bus_b.frame_o) begin
                if (prev_frame >= 0) begin
                    check("frame_period", 32'(c - prev_frame), 32'(ND * DIV));
                end
                prev_frame = c;
            end
        end
        check("frame_last_seen", 32'(prev_frame), 32'(2 * ND * DIV));

        // Reset during SHOW of digit 2, then a fresh snapshot.
        drive(16'h4321, 4'h0, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c <= 2 * DIV + 4; c++) begin
            step();
        end
        check("mid an_b before rst", 32'(bus_b.an_o), 32'hB);
        check("mid idx_b before rst", 32'(bus_b.digit_idx_o), 32'h2);
        drive(16'h1234, 4'h0, 4'hF);
        rst = 1'b1;
        step();
        check_reset("mid");
        check("mid rst idx_n", 32'(bus_n.digit_idx_o), 32'h0);
        rst = 1'b0;
        step();
        check("mid rel frm_b", 32'(bus_b.frame_o), 32'h1);
        check("mid rel idx_b", 32'(bus_b.digit_idx_o), 32'h0);
        check("mid rel bcd_b", 32'(bus_b.bcd_o), 32'h4);
        check("mid rel an_b", 32'(bus_b.an_o), 32'hF);
        check("mid rel an_n", 32'(bus_n.an_o), 32'hE);
        step();
        check("mid c1 an_b", 32'(bus_b.an_o), 32'hF);
        step();
        check("mid c2 an_b", 32'(bus_b.an_o), 32'hE);
        check("mid c2 bcd_b", 32'(bus_b.bcd_o), 32'h4);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
